// File: rtl/mac_accumulate_module_16bit_pkg.sv
// rtl/mac_accumulate_module_16bit_pkg.sv - shared types and widths for the MAC accumulator
package mac_accumulate_module_16bit_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int DEF_PROD_W = 16;
   localparam int DEF_ACC_W  = 24;

   localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
   localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/mac_accumulate_module_16bit_sat_add.sv
// rtl/mac_accumulate_module_16bit_sat_add.sv - saturating signed add of one product into the accumulator
module sat_add_module
   import mac_accumulate_module_16bit_pkg::*;
#(
   parameter int PROD_W = DEF_PROD_W,
   parameter int ACC_W  = DEF_ACC_W
) (
   input  logic signed [ACC_W-1:0]  acc,
   input  logic signed [PROD_W-1:0] prod,
   output logic signed [ACC_W-1:0]  sum,
   output logic                     sat
);

   localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W:0] wide;

   // One guard bit: the true sum fits in ACC_W+1, so a disagreement between
   // the top two bits means the ACC_W-bit result is out of range.
   always_comb begin
      wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
      sat  = wide[ACC_W] ^ wide[ACC_W-1];
      if (sat) begin
         sum = wide[ACC_W] ? MIN_V : MAX_V;
      end else begin
         sum = wide[ACC_W-1:0];
      end
   end

endmodule

// File: rtl/mac_accumulate_module_16bit.sv
// rtl/mac_accumulate_module_16bit.sv - sums N_TERMS signed products with saturation, valid/ready result
module mac_accumulate_module_16bit
   import mac_accumulate_module_16bit_pkg::*;
#(
   parameter int PROD_W  = DEF_PROD_W,
   parameter int ACC_W   = DEF_ACC_W,
   parameter int N_TERMS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     prod_valid,
   input  logic signed [PROD_W-1:0] prod,
   output logic                     prod_ready,
   output logic                     acc_valid,
   input  logic                     acc_ready,
   output logic signed [ACC_W-1:0]  acc_out,
   output logic                     overflow,
   output logic                     busy,
   output logic [7:0]               term_count
);

   localparam logic [7:0] N_LAST = 8'(N_TERMS);

   state_t                  state;
   logic signed [ACC_W-1:0] sum;
   logic                    sat;
   logic [7:0]              next_count;

   assign next_count = term_count + 8'd1;

   sat_add_module #(
      .PROD_W(PROD_W),
      .ACC_W (ACC_W)
   ) u_sat_add (
      .acc (acc_out),
      .prod(prod),
      .sum (sum),
      .sat (sat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         prod_ready <= 1'b0;
         acc_valid  <= 1'b0;
         acc_out    <= '0;
         overflow   <= 1'b0;
         busy       <= 1'b0;
         term_count <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= ACCUM;
                  prod_ready <= 1'b1;
                  busy       <= 1'b1;
                  acc_out    <= '0;
                  overflow   <= 1'b0;
                  term_count <= 8'd0;
               end
            end
            ACCUM: begin
               // A restart wins over a product offered in the same cycle.
               if (start) begin
                  acc_out    <= '0;
                  overflow   <= 1'b0;
                  term_count <= 8'd0;
               end else if (prod_valid && prod_ready) begin
                  acc_out    <= sum;
                  overflow   <= overflow | sat;
                  term_count <= next_count;
                  if (next_count == N_LAST) begin
                     state      <= DONE;
                     prod_ready <= 1'b0;
                     acc_valid  <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (acc_ready) begin
                  state     <= IDLE;
                  acc_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               prod_ready <= 1'b0;
               acc_valid  <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_accumulate_module_16bit.sv
// tb/tb_mac_accumulate_module_16bit.sv - directed self-checking bench for the MAC accumulator
module tb_mac_accumulate_module_16bit;

   logic clk = 1'b0;
   logic reset;

   // Default build: 16-bit products, 24-bit accumulator, 8 terms
   logic               start, prod_valid, acc_ready;
   logic signed [15:0] prod;
   logic               prod_ready, acc_valid, overflow, busy;
   logic signed [23:0] acc_out;
   logic [7:0]         term_count;

   // Narrow builds: 18-bit accumulator with 8 terms (b) and 1 term (c), shared inputs
   logic               s_start, s_valid, s_ready;
   logic signed [15:0] s_prod;
   logic               b_prod_ready, b_acc_valid, b_overflow, b_busy;
   logic signed [17:0] b_acc_out;
   logic [7:0]         b_term_count;
   logic               c_prod_ready, c_acc_valid, c_overflow, c_busy;
   logic signed [17:0] c_acc_out;
   logic [7:0]         c_term_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mac_accumulate_module_16bit dut (
      .clk(clk), .reset(reset), .start(start), .prod_valid(prod_valid), .prod(prod),
      .prod_ready(prod_ready), .acc_valid(acc_valid), .acc_ready(acc_ready),
      .acc_out(acc_out), .overflow(overflow), .busy(busy), .term_count(term_count)
   );

   mac_accumulate_module_16bit #(.ACC_W(18), .N_TERMS(8)) dut_b (
      .clk(clk), .reset(reset), .start(s_start), .prod_valid(s_valid), .prod(s_prod),
      .prod_ready(b_prod_ready), .acc_valid(b_acc_valid), .acc_ready(s_ready),
      .acc_out(b_acc_out), .overflow(b_overflow), .busy(b_busy), .term_count(b_term_count)
   );

   mac_accumulate_module_16bit #(.ACC_W(18), .N_TERMS(1)) dut_c (
      .clk(clk), .reset(reset), .start(s_start), .prod_valid(s_valid), .prod(s_prod),
      .prod_ready(c_prod_ready), .acc_valid(c_acc_valid), .acc_ready(s_ready),
      .acc_out(c_acc_out), .overflow(c_overflow), .busy(c_busy), .term_count(c_term_count)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Starts a sum with value v held on prod; returns edges from the start edge to acc_valid.
   task automatic run_const(input logic signed [15:0] v, output int edges);
      @(negedge clk);
      start = 1'b1; prod_valid = 1'b1; prod = v;
      @(negedge clk);
      start = 1'b0;
      edges = 1;
      while (!acc_valid && edges < 50) begin
         @(negedge clk);
         edges++;
      end
      prod_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({prod_ready, acc_valid, overflow, busy} !== 4'b0000 || acc_out !== 24'sd0 || term_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_state: rdy=%b vld=%b ovf=%b busy=%b acc=%0h cnt=%0d, expected all 0",
                  prod_ready, acc_valid, overflow, busy, acc_out, term_count);
      end
   endtask

   task automatic test_basic_sum();
      int edges;
      run_const(16'sd16129, edges);
      checks++;
      if (edges !== 9) begin
         errors++; $display("FAIL basic_latency: got %0d edges, expected 9", edges);
      end
      checks++;
      if (acc_out !== 24'h01F808 || overflow !== 1'b0 || term_count !== 8'd8) begin
         errors++;
         $display("FAIL basic_result: acc=%h ovf=%b cnt=%0d, expected 01f808 0 8", acc_out, overflow, term_count);
      end
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
      checks++;
      if (acc_valid !== 1'b0 || busy !== 1'b0 || acc_out !== 24'h01F808) begin
         errors++;
         $display("FAIL basic_handoff: vld=%b busy=%b acc=%h, expected 0 0 01f808", acc_valid, busy, acc_out);
      end
   endtask

   task automatic test_negative_sum();
      int edges;
      run_const(-16'sd16256, edges);
      checks++;
      if (acc_valid !== 1'b1 || acc_out !== 24'hFE0400 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL negative_result: vld=%b acc=%h ovf=%b, expected 1 fe0400 0", acc_valid, acc_out, overflow);
      end
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int exp_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         prod_valid = (i % 2 == 0);
         prod = 16'(i / 2 + 1);
         @(negedge clk);
         if (i % 2 == 0) exp_cnt++;
         checks++;
         if (term_count !== 8'(exp_cnt)) begin
            errors++; $display("FAIL stall_count[%0d]: got %0d, expected %0d", i, term_count, exp_cnt);
         end
      end
      prod_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (acc_valid !== 1'b1 || acc_out !== 24'sd36 || prod_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_result[%0d]: vld=%b acc=%0d rdy=%b, expected 1 36 0", i, acc_valid, acc_out, prod_ready);
         end
      end
   endtask

   task automatic test_ignored_start();
      @(negedge clk);
      start = 1'b1; prod_valid = 1'b1; prod = 16'sd500;
      @(negedge clk);
      start = 1'b0; prod_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (acc_valid !== 1'b1 || acc_out !== 24'sd36 || term_count !== 8'd8 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ignored_start: vld=%b acc=%0d cnt=%0d busy=%b, expected 1 36 8 1", acc_valid, acc_out, term_count, busy);
      end
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
      checks++;
      if (acc_valid !== 1'b0 || prod_ready !== 1'b0 || busy !== 1'b0 || acc_out !== 24'sd36) begin
         errors++;
         $display("FAIL drain_to_idle: vld=%b rdy=%b busy=%b acc=%0d, expected 0 0 0 36", acc_valid, prod_ready, busy, acc_out);
      end
   endtask

   task automatic test_abort();
      int edges;
      @(negedge clk);
      start = 1'b1; prod_valid = 1'b1; prod = 16'sd100;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (term_count !== 8'd3 || acc_out !== 24'sd300) begin
         errors++; $display("FAIL abort_pre: cnt=%0d acc=%0d, expected 3 300", term_count, acc_out);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (term_count !== 8'd0 || acc_out !== 24'sd0 || prod_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_clear: cnt=%0d acc=%0d rdy=%b busy=%b, expected 0 0 1 1", term_count, acc_out, prod_ready, busy);
      end
      edges = 0;
      while (!acc_valid && edges < 50) begin
         @(negedge clk);
         edges++;
      end
      prod_valid = 1'b0;
      checks++;
      if (edges !== 8 || acc_out !== 24'sd800) begin
         errors++; $display("FAIL abort_resum: edges=%0d acc=%0d, expected 8 800", edges, acc_out);
      end
      acc_ready = 1'b1;
      @(negedge clk);
      acc_ready = 1'b0;
   endtask

   task automatic test_reset_mid_sum();
      @(negedge clk);
      start = 1'b1; prod_valid = 1'b1; prod = -16'sd7;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (term_count !== 8'd5 || acc_out !== -24'sd35) begin
         errors++; $display("FAIL reset_mid_pre: cnt=%0d acc=%0d, expected 5 -35", term_count, acc_out);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({prod_ready, acc_valid, overflow, busy} !== 4'b0000 || acc_out !== 24'sd0 || term_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid: rdy=%b vld=%b ovf=%b busy=%b acc=%0d cnt=%0d, expected all 0",
                  prod_ready, acc_valid, overflow, busy, acc_out, term_count);
      end
      repeat (10) @(negedge clk);
      prod_valid = 1'b0;
      checks++;
      if (acc_valid !== 1'b0 || busy !== 1'b0 || term_count !== 8'd0) begin
         errors++; $display("FAIL reset_mid_idle: vld=%b busy=%b cnt=%0d, expected 0 0 0", acc_valid, busy, term_count);
      end
   endtask

   task automatic test_saturation();
      int edges;
      @(negedge clk);
      s_start = 1'b1; s_valid = 1'b1; s_prod = 16'sd16384;
      @(negedge clk);
      s_start = 1'b0;
      edges = 1;
      while (!b_acc_valid && edges < 50) begin
         @(negedge clk);
         edges++;
      end
      s_valid = 1'b0;
      checks++;
      if (b_acc_valid !== 1'b1 || b_acc_out !== 18'sd131071 || b_overflow !== 1'b1) begin
         errors++;
         $display("FAIL sat_clamp: vld=%b acc=%0d ovf=%b, expected 1 131071 1", b_acc_valid, b_acc_out, b_overflow);
      end
      checks++;
      if (c_acc_valid !== 1'b1 || c_acc_out !== 18'sd16384 || c_overflow !== 1'b0 || c_term_count !== 8'd1) begin
         errors++;
         $display("FAIL one_term_sum: vld=%b acc=%0d ovf=%b cnt=%0d, expected 1 16384 0 1",
                  c_acc_valid, c_acc_out, c_overflow, c_term_count);
      end
      s_ready = 1'b1;
      @(negedge clk);
      s_ready = 1'b0;
      s_start = 1'b1; s_valid = 1'b1; s_prod = 16'sd1;
      @(negedge clk);
      s_start = 1'b0;
      checks++;
      if (b_overflow !== 1'b0 || b_term_count !== 8'd0 || b_acc_out !== 18'sd0) begin
         errors++; $display("FAIL sat_restart: ovf=%b cnt=%0d acc=%0d, expected 0 0 0", b_overflow, b_term_count, b_acc_out);
      end
      @(negedge clk);
      s_valid = 1'b0; s_prod = 16'sd0;
      checks++;
      if (c_acc_valid !== 1'b1 || c_acc_out !== 18'sd1 || c_overflow !== 1'b0) begin
         errors++; $display("FAIL one_term_after_sat: vld=%b acc=%0d ovf=%b, expected 1 1 0", c_acc_valid, c_acc_out, c_overflow);
      end
      checks++;
      if (b_acc_valid !== 1'b0 || b_term_count !== 8'd1 || b_acc_out !== 18'sd1 || b_overflow !== 1'b0) begin
         errors++;
         $display("FAIL sat_first_term: vld=%b cnt=%0d acc=%0d ovf=%b, expected 0 1 1 0",
                  b_acc_valid, b_term_count, b_acc_out, b_overflow);
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; prod_valid = 1'b0; prod = '0; acc_ready = 1'b0;
      s_start = 1'b0; s_valid = 1'b0; s_prod = '0; s_ready = 1'b0;
      test_reset();
      test_basic_sum();
      test_negative_sum();
      test_backpressure();
      test_ignored_start();
      test_abort();
      test_reset_mid_sum();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mac_accumulate_module_16bit.md
Name: mac_accumulate_module_16bit

Overview:
Accumulator stage downstream of the 8-bit Booth multiplier. It consumes the signed 16-bit product stream Y, one product per handshake, and sums N_TERMS products into a signed accumulator with saturation. It presents the completed dot-product result on a valid/ready output port. This closes the multiply-accumulate datapath of the ALU.

Parameters:
PROD_W, 16, product width; must match the multiplier output Y.
ACC_W, 24, accumulator and result width; must be at least PROD_W+1.
N_TERMS, 8, products summed per result; range 1..255.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle pulse; clears the accumulator and begins a new sum.
prod_valid  input  1  a product is present on prod.
prod  input  PROD_W  signed product, driven from multiplier Y.
prod_ready  output  1  block accepts a product this cycle.
acc_valid  output  1  result is available on acc_out.
acc_ready  input  1  consumer takes the result.
acc_out  output  ACC_W  signed accumulated result.
overflow  output  1  sticky flag: saturation occurred during the current sum.
busy  output  1  high in ACCUM and DONE states.
term_count  output  8  number of products accepted in the current sum.

Behaviour:
- Reset: clk and reset are the only clock and reset. Reset is synchronous and active-high. On reset, state=IDLE and prod_ready, acc_valid, acc_out, overflow, busy and term_count all go to 0. Reset asserted mid-sum discards the partial sum; no result is emitted.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: prod_ready=0 and acc_valid=0. start moves to ACCUM on the next edge, clearing acc, overflow and term_count.
- ACCUM:
  - prod_ready=1.
  - A transfer occurs when prod_valid && prod_ready.
  - On each transfer, acc <= sat(acc + sign_extend(prod)) and term_count increments.
  - When the transfer brings term_count to N_TERMS, the next state is DONE.
  - prod_valid=0 stalls with no change.
- DONE:
  - acc_valid=1, prod_ready=0, and acc_out is stable.
  - acc_ready moves to IDLE on the next edge, with acc_valid deasserting.
  - acc_out holds its last value after the handoff.
- Latency: acc_valid asserts on the cycle after the final transfer. Minimum time from start to acc_valid is N_TERMS+1 cycles with prod_valid held high.
- Saturation:
  - The sum is computed at ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1, clamp to the maximum; below -2^(ACC_W-1), clamp to the minimum.
  - Either clamp sets overflow. overflow stays set until the next start or reset.
  - Later terms continue from the clamped value.
- acc_out tracks the running acc in ACCUM; it is only meaningful while acc_valid=1.
- start in ACCUM aborts the sum and restarts: clears acc, term_count and overflow, and stays in ACCUM. The start takes priority over a product transfer in the same cycle, and that product is not accepted.
- start in DONE is ignored. The result must be drained first.
- start and reset in the same cycle: reset wins.
- Registered outputs only; no combinational path from prod to acc_out.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, ACCUM=2'd1, DONE=2'd2;
  - the PROD_W/ACC_W defaults;
  - the ACC_MAX/ACC_MIN localparams derived from ACC_W.
- One sub-module, sat_add_module: combinational signed adder with sign extension of prod to ACC_W+1 bits, clamp logic, and an overflow-detect output. The FSM, counter and handshake live in the top module.

Test Plan:
- Basic sum: start, then 8 products of 16129 (127*127), prod_valid held high → acc_valid on cycle 9 after start, acc_out=0x01F808 (129032), overflow=0, term_count=8.
- Negative sum: 8 products of -16256 (-128*127) → acc_out=0xFE0400 (-130048), overflow=0.
- Saturation with ACC_W=18: 8 products of 16384 → acc_out=131071 (0x1FFFF), overflow=1. A following start then one product of 1 (N_TERMS=1 build) → overflow=0, acc_out=1.
- Backpressure and stall:
  - prod_valid toggled 1/0 → term_count advances only on transfers; acc_valid after 8 transfers.
  - acc_ready held low 5 cycles → acc_valid and acc_out stable, prod_ready=0.
  - acc_ready=1 → IDLE next cycle.
- Abort and reset:
  - start after 3 products → term_count=0 and acc=0 the next cycle; the same-cycle product is not counted.
  - reset after 5 products → all outputs 0, state IDLE, no acc_valid.
- Ignored start: pulse start while in DONE → acc_out unchanged and acc_valid stays 1 until acc_ready.
